// File: rtl/rf_wr_arbiter.sv
// Round-robin arbiter for the single register-file write port, with a
// registered write stage and a busy scoreboard of claimed destinations.
module rf_wr_arbiter #(
   parameter int NREQ = 3,
   parameter int XLEN = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ*5-1:0]      req_idx,
   input  logic [NREQ*XLEN-1:0]   req_data,
   output logic [NREQ-1:0]        req_ready,
   input  logic                   claim_en,
   input  logic [4:0]             claim_idx,
   output logic                   rf_wr_en,
   output logic [4:0]             rf_wr_idx,
   output logic [XLEN-1:0]        rf_wr_data,
   output logic [31:0]            busy
);

   localparam int PW = $clog2(NREQ);
   localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

   logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
   logic            rf_wr_en_q, rf_wr_en_d;
   logic [4:0]      rf_wr_idx_q, rf_wr_idx_d;
   logic [XLEN-1:0] rf_wr_data_q, rf_wr_data_d;
   logic [31:0]     busy_q, busy_d;

   logic            gnt_any;
   logic [PW-1:0]   gnt_id;
   logic [PW:0]     cand;
   logic [4:0]      sel_idx;
   logic [XLEN-1:0] sel_data;

   // Scan offsets from high to low so the nearest valid requester at or
   // above rr_ptr is the last one written and therefore wins.
   always_comb begin
      gnt_any = 1'b0;
      gnt_id  = rr_ptr_q;
      cand    = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         cand = {1'b0, rr_ptr_q} + (PW+1)'(k);
         if (cand >= (PW+1)'(NREQ)) begin
            cand = cand - (PW+1)'(NREQ);
         end
         if (req_valid[cand[PW-1:0]]) begin
            gnt_any = 1'b1;
            gnt_id  = cand[PW-1:0];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (gnt_any) begin
         req_ready[gnt_id] = 1'b1;
      end
      sel_idx  = req_idx[int'(gnt_id)*5 +: 5];
      sel_data = req_data[int'(gnt_id)*XLEN +: XLEN];
   end

   always_comb begin
      rr_ptr_d     = rr_ptr_q;
      rf_wr_en_d   = 1'b0;
      rf_wr_idx_d  = rf_wr_idx_q;
      rf_wr_data_d = rf_wr_data_q;
      if (gnt_any) begin
         rr_ptr_d     = (gnt_id == LAST) ? '0 : gnt_id + 1'b1;
         rf_wr_en_d   = (sel_idx != 5'd0);
         rf_wr_idx_d  = sel_idx;
         rf_wr_data_d = sel_data;
      end
   end

   // A claim beats a commit to the same register in the same cycle.
   always_comb begin
      busy_d = busy_q;
      for (int r = 1; r < 32; r++) begin
         if (claim_en && claim_idx == 5'(r)) begin
            busy_d[r] = 1'b1;
         end else if (rf_wr_en_q && rf_wr_idx_q == 5'(r)) begin
            busy_d[r] = 1'b0;
         end
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q     <= '0;
         rf_wr_en_q   <= 1'b0;
         rf_wr_idx_q  <= 5'd0;
         rf_wr_data_q <= '0;
         busy_q       <= 32'd0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         rf_wr_en_q   <= rf_wr_en_d;
         rf_wr_idx_q  <= rf_wr_idx_d;
         rf_wr_data_q <= rf_wr_data_d;
         busy_q       <= busy_d;
      end
   end

   assign rf_wr_en   = rf_wr_en_q;
   assign rf_wr_idx  = rf_wr_idx_q;
   assign rf_wr_data = rf_wr_data_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Bench for rf_wr_arbiter: directed scenarios plus random traffic against a
// round-robin / scoreboard reference model, with a write monitor.
module tb_rf_wr_arbiter;
   localparam int NREQ = 3;
   localparam int XLEN = 32;

   logic                 clk;
   logic                 rst;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ*5-1:0]    req_idx;
   logic [NREQ*XLEN-1:0] req_data;
   logic [NREQ-1:0]      req_ready;
   logic                 claim_en;
   logic [4:0]           claim_idx;
   logic                 rf_wr_en;
   logic [4:0]           rf_wr_idx;
   logic [XLEN-1:0]      rf_wr_data;
   logic [31:0]          busy;

   rf_wr_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_idx    (req_idx),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .claim_en   (claim_en),
      .claim_idx  (claim_idx),
      .rf_wr_en   (rf_wr_en),
      .rf_wr_idx  (rf_wr_idx),
      .rf_wr_data (rf_wr_data),
      .busy       (busy)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;

   // expected committed writes: {idx, data}
   logic [4+XLEN:0] exp_q[$];
   logic [4+XLEN:0] mon_exp;

   // reference model state
   int              ptr_m;
   logic [31:0]     busy_m;
   logic            pend_en;
   logic [4:0]      pend_idx;
   logic [NREQ-1:0] last_ready;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      ptr_m    = 0;
      busy_m   = 32'd0;
      pend_en  = 1'b0;
      pend_idx = 5'd0;
   endtask

   // One cycle: drive at negedge, check grant/busy against the model,
   // advance the model to the state after the coming edge.
   task automatic drive_cycle(input logic [NREQ-1:0] v, input logic [NREQ*5-1:0] idx,
                              input logic [NREQ*XLEN-1:0] dat, input logic ce,
                              input logic [4:0] ci);
      int          w;
      logic [4:0]  widx;
      logic [31:0] nb;
      @(negedge clk);
      req_valid = v;
      req_idx   = idx;
      req_data  = dat;
      claim_en  = ce;
      claim_idx = ci;
      #1;
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
         if (w < 0 && v[(ptr_m + k) % NREQ]) w = (ptr_m + k) % NREQ;
      end
      last_ready = req_ready;
      check("req_ready", 64'(req_ready), (w < 0) ? 64'd0 : (64'd1 << w));
      check("busy", 64'(busy), 64'(busy_m));
      nb = busy_m;
      if (pend_en) nb[pend_idx] = 1'b0;
      if (ce && ci != 5'd0) nb[ci] = 1'b1;
      pend_en = 1'b0;
      if (w >= 0) begin
         widx  = idx[w*5 +: 5];
         ptr_m = (w + 1) % NREQ;
         if (widx != 5'd0) begin
            exp_q.push_back({widx, dat[w*XLEN +: XLEN]});
            pend_en  = 1'b1;
            pend_idx = widx;
         end
      end
      busy_m = nb;
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive_cycle('0, '0, '0, 1'b0, 5'd0);
   endtask

   task automatic one_req(input int r, input logic [4:0] idx, input logic [XLEN-1:0] d,
                          input logic ce, input logic [4:0] ci);
      logic [NREQ-1:0]      v;
      logic [NREQ*5-1:0]    iv;
      logic [NREQ*XLEN-1:0] dv;
      v = '0; iv = '0; dv = '0;
      v[r] = 1'b1;
      iv[r*5 +: 5] = idx;
      dv[r*XLEN +: XLEN] = d;
      drive_cycle(v, iv, dv, ce, ci);
   endtask

   task automatic rand_cycle(input logic [NREQ-1:0] v, input logic ce);
      logic [NREQ*5-1:0]    iv;
      logic [NREQ*XLEN-1:0] dv;
      for (int i = 0; i < NREQ; i++) begin
         iv[i*5 +: 5]       = 5'($urandom_range(0, 31));
         dv[i*XLEN +: XLEN] = $urandom;
      end
      drive_cycle(v, iv, dv, ce, 5'($urandom_range(0, 31)));
   endtask

   // monitor: every presented write must match the oldest expected one
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && rf_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL spurious_write: got idx %0d data %0h expected no write", rf_wr_idx, rf_wr_data);
            end else begin
               mon_exp = exp_q.pop_front();
               check("rf_write", 64'({rf_wr_idx, rf_wr_data}), 64'(mon_exp));
            end
         end
      end
   end

   int order_a[6] = '{0, 1, 2, 0, 1, 2};
   int order_b[3] = '{1, 2, 1};

   initial begin
      rst = 1'b1;
      req_valid = '0; req_idx = '0; req_data = '0;
      claim_en = 1'b0; claim_idx = 5'd0;
      model_reset();
      #1;
      check("reset_wr_en", 64'(rf_wr_en), 64'd0);
      check("reset_wr_idx", 64'(rf_wr_idx), 64'd0);
      check("reset_wr_data", 64'(rf_wr_data), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // single requester latency
      one_req(0, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
      #1;
      check("single_en_k1", 64'(rf_wr_en), 64'd1);
      check("single_idx_k1", 64'(rf_wr_idx), 64'd5);
      check("single_data_k1", 64'(rf_wr_data), 64'hDEADBEEF);
      idle(1);
      #1;
      check("single_en_k2", 64'(rf_wr_en), 64'd0);

      // contention: bring pointer to 0 via a grant to 2, then all valid
      one_req(2, 5'd3, 32'h1, 1'b0, 5'd0);
      for (int i = 0; i < 6; i++) begin
         rand_cycle(3'b111, 1'b0);
         check("contend_all", 64'(last_ready), 64'd1 << order_a[i]);
      end
      for (int i = 0; i < 3; i++) begin
         rand_cycle(3'b110, 1'b0);
         check("contend_12", 64'(last_ready), 64'd1 << order_b[i]);
      end
      idle(2);

      // write to x0 accepted and dropped
      one_req(1, 5'd0, 32'h1234, 1'b0, 5'd0);
      check("x0_ready", 64'(last_ready), 64'b010);
      #1;
      check("x0_wr_en", 64'(rf_wr_en), 64'd0);
      check("x0_busy", 64'(busy), 64'd0);
      rand_cycle(3'b111, 1'b0);
      check("x0_ptr_next", 64'(last_ready), 64'b100);
      idle(2);

      // scoreboard claim / commit timing
      one_req(0, 5'd0, 32'h0, 1'b1, 5'd7);
      idle(0);
      #1;
      check("sb_set_k1", 64'(busy[7]), 64'd1);
      idle(2);
      one_req(0, 5'd7, 32'hA5A5_0007, 1'b0, 5'd0);
      #1;
      check("sb_still_k4", 64'(busy[7]), 64'd1);
      idle(1);
      #1;
      check("sb_clear_k5", 64'(busy[7]), 64'd0);
      drive_cycle('0, '0, '0, 1'b1, 5'd7);
      idle(2);
      one_req(1, 5'd7, 32'h7777, 1'b0, 5'd0);
      drive_cycle('0, '0, '0, 1'b1, 5'd7);
      #1;
      check("sb_reclaim_wins", 64'(busy[7]), 64'd1);
      one_req(2, 5'd7, 32'h8888, 1'b0, 5'd0);
      idle(2);

      // claim x0 together with commit to x9
      drive_cycle('0, '0, '0, 1'b1, 5'd9);
      one_req(0, 5'd9, 32'h9999, 1'b0, 5'd0);
      drive_cycle('0, '0, '0, 1'b1, 5'd0);
      #1;
      check("claim_x0_bit0", 64'(busy[0]), 64'd0);
      check("commit_x9_clear", 64'(busy[9]), 64'd0);

      // asynchronous reset mid-stream
      for (int r = 4; r < 8; r++) drive_cycle('0, '0, '0, 1'b1, 5'(r));
      one_req(0, 5'd10, 32'hCAFE_F00D, 1'b0, 5'd0);
      @(negedge clk);
      req_valid = '0; claim_en = 1'b0;
      #1;
      check("pre_rst_wr_en", 64'(rf_wr_en), 64'd1);
      check("pre_rst_busy", 64'(busy), 64'h0000_00F0);
      #1 rst = 1'b1;
      #1;
      check("async_rst_wr_en", 64'(rf_wr_en), 64'd0);
      check("async_rst_busy", 64'(busy), 64'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      one_req(2, 5'd11, 32'h2222, 1'b0, 5'd0);
      check("post_rst_sole2", 64'(last_ready), 64'b100);

      // random traffic against the model
      for (int i = 0; i < 400; i++) begin
         rand_cycle(NREQ'($urandom_range(0, (1 << NREQ) - 1)), 1'($urandom_range(0, 1)));
      end
      idle(3);
      check("drain_empty", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/rf_wr_arbiter.md
# rf_wr_arbiter

Shares the single register-file write port between `NREQ` writeback requesters (ALU, load unit, multiplier, …) using round-robin arbitration with a valid/ready handshake. It registers the winning write onto the register-file write port and keeps a 32-bit busy scoreboard of destination registers that have a claimed write not yet committed. Issue logic uses the scoreboard to stall. The block sits between the execute/memory writeback paths and the register file.

## Interface

Parameters:
- `NREQ`, default 3: number of writeback requesters; legal range 2..8.
- `XLEN`, default 32: data width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  NREQ  requester i has a write pending.
- `req_idx`  in  NREQ×5  destination register per requester.
- `req_data`  in  NREQ×XLEN  write data per requester.
- `req_ready`  out  NREQ  grant; the transfer happens on a cycle where `req_valid[i] && req_ready[i]`.
- `claim_en`  in  1  issue stage reserves a destination this cycle.
- `claim_idx`  in  5  reserved destination.
- `rf_wr_en`  out  1  to regfile `wr_en`, registered.
- `rf_wr_idx`  out  5  to regfile `wr_idx`, registered.
- `rf_wr_data`  out  XLEN  to regfile `wr_data`, registered.
- `busy`  out  32  scoreboard; bit r=1 means register r has an uncommitted claimed write. Bit 0 is always 0.

## Operation

- Arbitration is combinational within the cycle. Among requesters with `req_valid` high, the grant goes to the first one found searching upward from `rr_ptr`, wrapping modulo NREQ.
- At most one `req_ready` bit is high per cycle. `req_ready[i]` is never high while `req_valid[i]` is low.
- Pointer update: on a grant to requester w, `rr_ptr` becomes (w+1) mod NREQ at the next edge. With no grant, `rr_ptr` holds.
- The write port never backpressures, so a grant occurs on every cycle with any valid request.
- Output stage, at each edge:
  - `rf_wr_en` loads "grant occurred and granted idx != 0".
  - `rf_wr_idx` and `rf_wr_data` load the granted idx and data.
  - With no grant, `rf_wr_en` loads 0 and idx/data hold their previous values.
- Writes to x0 are accepted (ready given, pointer advances) and silently dropped: `rf_wr_en` stays 0 and `busy` is unaffected.
- Scoreboard, per edge, for each r in 1..31:
  - Set when `claim_en && claim_idx==r`.
  - Else clear when `rf_wr_en && rf_wr_idx==r`.
  - Else hold.
- A claim to x0 is ignored. Claiming an already busy register leaves it busy; there is no count, and the first commit clears it.
- A simultaneous claim and commit to the same register: claim wins, and the bit stays 1.

## Timing

- Reset (async, immediate): `rf_wr_en`=0, `rf_wr_idx`=0, `rf_wr_data`=0, `busy`=0, `rr_ptr`=0. `req_ready` then follows the combinational grant from `rr_ptr`=0.
- Reset mid-operation discards the in-flight output-stage write; the regfile is itself reset by the same `rst`.
- Latency for a transfer accepted in cycle k:
  - `rf_wr_en`=1 during cycle k+1.
  - The regfile array updates at the end of k+1.
  - The data is readable in cycle k+2.
  - `busy` clears at the same edge as the regfile write, so `busy[r]`=0 guarantees the register holds the committed value.
- Throughput: one write per cycle, sustained.
- Fairness: a continuously valid requester is granted within NREQ cycles.
- `req_valid`, `req_idx` and `req_data` must be stable only while sampled; a requester may drop `req_valid` without a grant.

## Test plan

- Reset: assert `rst` mid-stream with `rf_wr_en`=1 and `busy`=0x0000_00F0. Both go to 0 immediately, with no clock edge needed. After release, a sole `req_valid[2]` gets `req_ready`=3'b100.
- Single requester: `req_valid[0]`, idx=5, data=0xDEADBEEF in cycle k. `rf_wr_en`=1, idx=5, data=0xDEADBEEF in cycle k+1; 0 in k+2. Regfile x5 reads 0xDEADBEEF in k+2.
- Contention with NREQ=3: all three valid continuously for 6 cycles, starting from `rr_ptr`=0. Grant order is 0,1,2,0,1,2, one-hot each cycle.
  - Then with only 1 and 2 valid after a grant to 2, order is 1,2,1.
- x0 write: requester 1 writes idx=0, data=0x1234. `req_ready[1]`=1 and `rr_ptr`→2, but `rf_wr_en` stays 0 and `busy`=0.
- Scoreboard:
  - Claim idx=7 in cycle k: `busy[7]`=1 from k+1.
  - A write to 7 accepted in k+3: `busy[7]` clears at the end of k+4.
  - Repeat with a re-claim of 7 in k+4: `busy[7]` stays 1.
- Claim x0 together with a commit to x9: `busy[0]` stays 0 and `busy[9]` clears.
